// File: rtl/dds_timer_pkg.sv
// Shared definitions for the multi-channel DDS dwell timer: channel state
// encoding and the per-channel control bundle.
package dds_timer_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } ch_state_e;

    typedef struct packed {
        logic en;
        logic clr;
        logic wrap;
    } ch_ctl_t;

endpackage

// File: rtl/dds_timer_ch.sv
// One dwell-timer channel: gated up-counter with unsigned terminal compare,
// periodic (wrap) or one-shot (stop) terminal behaviour.
module dds_timer_ch
    import dds_timer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_sys,
    input  logic             rst_n,
    input  ch_ctl_t          ctl,
    input  logic [WIDTH-1:0] term_val,
    output logic [WIDTH-1:0] count,
    output logic             tc_pulse,
    output logic             done,
    output logic             done_next
);

    ch_state_e        state, state_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic             tc_nxt;
    logic             done_nxt;
    logic             at_term;

    // >= rather than == so a term_val lowered below count still terminates,
    // which also keeps count from ever reaching the 2^WIDTH wrap.
    assign at_term   = (count >= term_val);
    assign done_next = done_nxt;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            count    <= '0;
            tc_pulse <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            tc_pulse <= tc_nxt;
            done     <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        tc_nxt    = 1'b0;
        done_nxt  = done;
        if (ctl.clr || !ctl.en) begin
            state_nxt = S_IDLE;
            count_nxt = '0;
            done_nxt  = 1'b0;
        end else begin
            case (state)
                // IDLE always holds count=0, so it takes the RUN action directly.
                S_IDLE, S_RUN: begin
                    if (at_term) begin
                        tc_nxt = 1'b1;
                        if (ctl.wrap) begin
                            count_nxt = '0;
                            state_nxt = S_RUN;
                        end else begin
                            done_nxt  = 1'b1;
                            state_nxt = S_DONE;
                        end
                    end else begin
                        count_nxt = count + WIDTH'(1);
                        state_nxt = S_RUN;
                    end
                end
                S_DONE: begin
                    state_nxt = S_DONE;
                end
                default: begin
                    state_nxt = S_IDLE;
                    count_nxt = '0;
                    done_nxt  = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/dds_timer_multi.sv
// Multi-channel DDS dwell timer: CH independent gated timers plus a
// registered any_done summary aligned with the per-channel done flags.
module dds_timer_multi
    import dds_timer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CH    = 4
) (
    input  logic                clk_sys,
    input  logic                rst_n,
    input  logic [CH-1:0]       state_start,
    input  logic [CH-1:0]       state_over,
    input  logic [CH-1:0]       clr,
    input  logic [CH-1:0]       mode_wrap,
    input  logic [CH*WIDTH-1:0] term_val,
    output logic [CH*WIDTH-1:0] count,
    output logic [CH-1:0]       tc_pulse,
    output logic [CH-1:0]       done,
    output logic                any_done
);

    logic [CH-1:0] done_nxt;

    for (genvar g = 0; g < CH; g++) begin : g_ch
        ch_ctl_t ctl;

        assign ctl.en   = state_start[g] & state_over[g];
        assign ctl.clr  = clr[g];
        assign ctl.wrap = mode_wrap[g];

        dds_timer_ch #(
            .WIDTH (WIDTH)
        ) u_ch (
            .clk_sys   (clk_sys),
            .rst_n     (rst_n),
            .ctl       (ctl),
            .term_val  (term_val[g*WIDTH +: WIDTH]),
            .count     (count[g*WIDTH +: WIDTH]),
            .tc_pulse  (tc_pulse[g]),
            .done      (done[g]),
            .done_next (done_nxt[g])
        );
    end

    // Registering the OR of next-state done keeps any_done cycle-aligned with done.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) any_done <= 1'b0;
        else        any_done <= |done_nxt;
    end

endmodule

// File: tb/tb_dds_timer_multi.sv
// Self-checking bench for dds_timer_multi: directed scenarios plus random
// stimulus, compared every cycle against a behavioural timer model.
module tb_dds_timer_multi;

    localparam int CH = 4;
    localparam int W  = 8;

    logic            clk_sys = 1'b0;
    logic            rst_n   = 1'b0;
    logic [CH-1:0]   ss, so, clr, mw;
    logic [CH*W-1:0] tv;
    logic [CH*W-1:0] cnt;
    logic [CH-1:0]   tc, dn;
    logic            anyd;

    logic        ss16, so16, clr16, mw16;
    logic [15:0] tv16, cnt16;
    logic        tc16, dn16, anyd16;
    bit          w16_done = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    int m_cnt[CH];
    bit m_dn[CH];
    bit m_tc[CH];

    always #5 clk_sys = ~clk_sys;

    dds_timer_multi #(.WIDTH(W), .CH(CH)) u_dut (
        .clk_sys     (clk_sys),
        .rst_n       (rst_n),
        .state_start (ss),
        .state_over  (so),
        .clr         (clr),
        .mode_wrap   (mw),
        .term_val    (tv),
        .count       (cnt),
        .tc_pulse    (tc),
        .done        (dn),
        .any_done    (anyd)
    );

    dds_timer_multi #(.WIDTH(16), .CH(1)) u_w16 (
        .clk_sys     (clk_sys),
        .rst_n       (rst_n),
        .state_start (ss16),
        .state_over  (so16),
        .clr         (clr16),
        .mode_wrap   (mw16),
        .term_val    (tv16),
        .count       (cnt16),
        .tc_pulse    (tc16),
        .done        (dn16),
        .any_done    (anyd16)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Timer behaviour straight from the rules: gate/clear zero everything,
    // a finished one-shot holds, otherwise compare then wrap/stop or count up.
    function automatic void mdl(input bit en, input bit cl, input bit wr, input int term,
                                input int c0, input bit d0,
                                output int c1, output bit d1, output bit t1);
        c1 = c0;
        d1 = d0;
        t1 = 1'b0;
        if (cl || !en) begin
            c1 = 0;
            d1 = 1'b0;
        end else if (!d0) begin
            if (c0 >= term) begin
                t1 = 1'b1;
                if (wr) c1 = 0;
                else    d1 = 1'b1;
            end else begin
                c1 = c0 + 1;
            end
        end
    endfunction

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_cnt[i] = 0;
            m_dn[i]  = 1'b0;
            m_tc[i]  = 1'b0;
        end
    endtask

    task automatic set_term(input int ch, input int v);
        logic [W-1:0] t;
        t = W'(v);
        tv[ch*W +: W] = t;
    endtask

    task automatic step(input string tag);
        int c1;
        bit d1, t1, any;
        @(posedge clk_sys);
        for (int i = 0; i < CH; i++) begin
            mdl(ss[i] & so[i], clr[i], mw[i], int'(tv[i*W +: W]), m_cnt[i], m_dn[i], c1, d1, t1);
            m_cnt[i] = c1;
            m_dn[i]  = d1;
            m_tc[i]  = t1;
        end
        #1;
        any = 1'b0;
        for (int i = 0; i < CH; i++) begin
            chk($sformatf("%s cnt%0d", tag, i), 32'(cnt[i*W +: W]), 32'(m_cnt[i]));
            chk($sformatf("%s tc%0d", tag, i), 32'(tc[i]), 32'(m_tc[i]));
            chk($sformatf("%s done%0d", tag, i), 32'(dn[i]), 32'(m_dn[i]));
            any = any | m_dn[i];
        end
        chk($sformatf("%s any_done", tag), 32'(anyd), 32'(any));
    endtask

    task automatic idle_all();
        ss = '0; so = '0; clr = '0; mw = '0;
        step("idle");
    endtask

    task automatic w16_run();
        int c, c1;
        bit d, d1, t1;
        c = 0; d = 1'b0;
        ss16 = 1'b1; so16 = 1'b1; mw16 = 1'b0; clr16 = 1'b0; tv16 = 16'hFFFF;
        for (int k = 1; k <= 65537; k++) begin
            @(posedge clk_sys);
            mdl(1'b1, 1'b0, 1'b0, 65535, c, d, c1, d1, t1);
            c = c1; d = d1;
            #1;
            chk("w16 cnt", 32'(cnt16), 32'(c));
            chk("w16 tc", 32'(tc16), 32'(t1));
            chk("w16 done", 32'(dn16), 32'(d));
            if (k == 65535) chk("w16 pre_done", 32'({cnt16, dn16}), 32'({16'hFFFF, 1'b0}));
            if (k == 65536) chk("w16 at_done", 32'({cnt16, dn16, tc16, anyd16}), 32'({16'hFFFF, 3'b111}));
            if (k == 65537) chk("w16 hold", 32'({cnt16, dn16, tc16}), 32'({16'hFFFF, 2'b10}));
        end
        so16 = 1'b0;
        @(posedge clk_sys);
        #1;
        chk("w16 gate_drop", 32'({cnt16, dn16, anyd16}), 32'(0));
        w16_done = 1'b1;
    endtask

    initial begin
        ss = '0; so = '0; clr = '0; mw = '0; tv = '0;
        ss16 = 1'b0; so16 = 1'b0; clr16 = 1'b0; mw16 = 1'b0; tv16 = '0;
        model_reset();
        repeat (2) @(posedge clk_sys);
        #1;
        chk("reset count", 32'(cnt), 32'(0));
        chk("reset tc_done", 32'({tc, dn, anyd}), 32'(0));
        @(negedge clk_sys);
        rst_n = 1'b1;

        // asynchronous reset in the middle of a count
        ss[0] = 1'b1; so[0] = 1'b1; mw[0] = 1'b1; set_term(0, 5);
        repeat (3) step("pre_rst");
        chk("pre_rst cnt", 32'(cnt[0 +: W]), 32'(3));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst cnt", 32'(cnt[0 +: W]), 32'(0));
        chk("async_rst flags", 32'({tc, dn, anyd}), 32'(0));
        model_reset();
        ss = '0; so = '0;
        @(negedge clk_sys);
        rst_n = 1'b1;

        fork
            w16_run();
        join_none

        // wrap, term=3
        idle_all();
        ss[1] = 1'b1; so[1] = 1'b1; mw[1] = 1'b1; set_term(1, 3);
        for (int k = 1; k <= 12; k++) begin
            step("wrap");
            chk("wrap seq", 32'(cnt[1*W +: W]), 32'(k % 4));
            chk("wrap tc", 32'(tc[1]), 32'(k % 4 == 0));
        end

        // one-shot, term=4
        idle_all();
        ss[2] = 1'b1; so[2] = 1'b1; mw[2] = 1'b0; set_term(2, 4);
        for (int k = 1; k <= 10; k++) begin
            step("oneshot");
            chk("oneshot cnt", 32'(cnt[2*W +: W]), 32'((k < 4) ? k : 4));
            chk("oneshot done", 32'(dn[2]), 32'(k >= 5));
            chk("oneshot tc", 32'(tc[2]), 32'(k == 5));
            chk("oneshot any", 32'(anyd), 32'(k >= 5));
        end
        ss[2] = 1'b0;
        step("oneshot_drop");
        chk("oneshot_drop", 32'({cnt[2*W +: W], dn[2], anyd}), 32'(0));

        // clear beats enable; gate drop clears then restarts
        idle_all();
        ss[3] = 1'b1; so[3] = 1'b1; set_term(3, 20);
        repeat (2) step("prio");
        chk("prio cnt2", 32'(cnt[3*W +: W]), 32'(2));
        clr[3] = 1'b1;
        step("prio_clr");
        chk("prio clr", 32'(cnt[3*W +: W]), 32'(0));
        clr[3] = 1'b0;
        repeat (6) step("prio_run");
        chk("prio cnt6", 32'(cnt[3*W +: W]), 32'(6));
        so[3] = 1'b0;
        step("prio_gate");
        chk("prio gate", 32'(cnt[3*W +: W]), 32'(0));
        so[3] = 1'b1;
        step("prio_restart");
        chk("prio restart", 32'(cnt[3*W +: W]), 32'(1));

        // term lowered mid-run, then term=0 in wrap mode
        idle_all();
        ss[0] = 1'b1; so[0] = 1'b1; mw[0] = 1'b1; set_term(0, 10);
        repeat (7) step("lower");
        chk("lower cnt7", 32'(cnt[0 +: W]), 32'(7));
        set_term(0, 4);
        step("lower_hit");
        chk("lower hit", 32'({cnt[0 +: W], tc[0]}), 32'({8'd0, 1'b1}));
        step("lower_next");
        chk("lower next", 32'({cnt[0 +: W], tc[0]}), 32'({8'd1, 1'b0}));
        set_term(0, 0);
        for (int k = 0; k < 4; k++) begin
            step("term0");
            chk("term0", 32'({cnt[0 +: W], tc[0]}), 32'({8'd0, 1'b1}));
        end

        // all channels together, mixed modes
        idle_all();
        ss = '1; so = '1; mw = 4'b0101;
        set_term(0, 2); set_term(1, 3); set_term(2, 5); set_term(3, 7);
        repeat (20) step("indep");

        // random traffic
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < CH; i++) begin
                ss[i]  = ($urandom_range(0, 9) != 0);
                so[i]  = ($urandom_range(0, 9) != 0);
                clr[i] = ($urandom_range(0, 29) == 0);
                if ($urandom_range(0, 19) == 0) mw[i] = ~mw[i];
                if ($urandom_range(0, 14) == 0) set_term(i, int'($urandom_range(0, 12)));
            end
            step("rand");
        end
        ss = '0; so = '0; clr = '0;

        for (int c = 0; c < 70000 && !w16_done; c++) @(posedge clk_sys);
        chk("w16 finished", 32'(w16_done), 32'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
